// File: rtl/pulse_width_decode_pkg.sv
// Shared definitions for the pulse width decoder: FSM state encoding and
// the counter/width sizing helper.
package pulse_width_decode_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_GUARD   = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    // Bits needed to hold values 0..max_val inclusive.
    function automatic int width_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pulse_width_ctr.sv
// Saturating up-counter with load-to-1, increment and an ==LIMIT compare.
// Used by the decoder for both the high-width and the low-gap count.
module pulse_width_ctr
    import pulse_width_decode_pkg::*;
#(
    parameter int LIMIT = 16,
    parameter int W     = width_w(LIMIT)
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         i_load,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt,
    output logic         o_at_lim
);

    logic [W-1:0] r_cnt;
    logic         w_at_lim;

    assign w_at_lim = (r_cnt == W'(LIMIT));

    // Load wins over increment; increment stops at LIMIT.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= W'(1);
        end else if (i_inc && !w_at_lim) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt    = r_cnt;
    assign o_at_lim = w_at_lim;

endmodule

// File: rtl/pulse_width_decode.sv
// Recovers one-cycle events from stretched level pulses, validating high width
// and low gap. Define PULSE_WIDTH_DECODE_SYNC_EN to add a 2-FF input synchronizer.
module pulse_width_decode
    import pulse_width_decode_pkg::*;
#(
    parameter int MIN_WIDTH = 4,
    parameter int MAX_WIDTH = 16,
    parameter int GAP_MIN   = 2
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic                           iS,
    output logic                           oP,
    output logic [width_w(MAX_WIDTH)-1:0]  oWIDTH,
    output logic                           oERR_SHORT,
    output logic                           oERR_LONG,
    output logic                           oERR_GAP
);

    localparam int W_W   = width_w(MAX_WIDTH);
    localparam int GAP_W = width_w(GAP_MIN);

    logic w_s;
    logic w_rise;
    logic r_s_d;

`ifdef PULSE_WIDTH_DECODE_SYNC_EN
    // Reset high so a level already asserted at reset release is not a rise.
    logic r_sync_1;
    logic r_sync_2;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sync_1 <= 1'b1;
            r_sync_2 <= 1'b1;
        end else begin
            r_sync_1 <= iS;
            r_sync_2 <= r_sync_1;
        end
    end

    assign w_s = r_sync_2;
`else
    assign w_s = iS;
`endif

    assign w_rise = w_s & ~r_s_d;

    state_t r_state;
    state_t w_state_next;

    logic             w_cnt_load;
    logic             w_cnt_inc;
    logic [W_W-1:0]   w_cnt;
    logic             w_cnt_at_lim;
    logic             w_gap_load;
    logic             w_gap_inc;
    logic [GAP_W-1:0] w_gap;
    logic             w_gap_at_lim;

    pulse_width_ctr #(
        .LIMIT (MAX_WIDTH),
        .W     (W_W)
    ) u_width_ctr (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .i_load   (w_cnt_load),
        .i_inc    (w_cnt_inc),
        .o_cnt    (w_cnt),
        .o_at_lim (w_cnt_at_lim)
    );

    pulse_width_ctr #(
        .LIMIT (GAP_MIN),
        .W     (GAP_W)
    ) u_gap_ctr (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .i_load   (w_gap_load),
        .i_inc    (w_gap_inc),
        .o_cnt    (w_gap),
        .o_at_lim (w_gap_at_lim)
    );

    logic           r_p;
    logic           r_err_short;
    logic           r_err_long;
    logic           r_err_gap;
    logic [W_W-1:0] r_width;

    logic           w_p_next;
    logic           w_err_short_next;
    logic           w_err_long_next;
    logic           w_err_gap_next;
    logic [W_W-1:0] w_width_next;

    always_comb begin
        w_state_next     = r_state;
        w_cnt_load       = 1'b0;
        w_cnt_inc        = 1'b0;
        w_gap_load       = 1'b0;
        w_gap_inc        = 1'b0;
        w_p_next         = 1'b0;
        w_err_short_next = 1'b0;
        w_err_long_next  = 1'b0;
        w_err_gap_next   = 1'b0;
        w_width_next     = r_width;

        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_cnt_load   = 1'b1;
                    w_state_next = ST_MEASURE;
                end
            end

            ST_MEASURE: begin
                if (w_s) begin
                    if (w_cnt_at_lim) begin
                        w_err_long_next = 1'b1;
                        w_state_next    = ST_DISCARD;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end else begin
                    if (w_cnt >= W_W'(MIN_WIDTH)) begin
                        w_p_next     = 1'b1;
                        w_width_next = w_cnt;
                    end else begin
                        w_err_short_next = 1'b1;
                    end
                    w_gap_load   = 1'b1;
                    w_state_next = ST_GUARD;
                end
            end

            ST_GUARD: begin
                // The first low sample was counted on entry, so the count
                // holds the number of lows seen since the fall.
                if (w_rise) begin
                    if (w_gap_at_lim) begin
                        w_cnt_load   = 1'b1;
                        w_state_next = ST_MEASURE;
                    end else begin
                        w_err_gap_next = 1'b1;
                        w_state_next   = ST_DISCARD;
                    end
                end else if (!w_s) begin
                    w_gap_inc = 1'b1;
                    if (w_gap >= GAP_W'(GAP_MIN - 1)) begin
                        w_state_next = ST_IDLE;
                    end
                end
            end

            ST_DISCARD: begin
                if (!w_s) begin
                    w_gap_load   = 1'b1;
                    w_state_next = ST_GUARD;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= ST_IDLE;
            r_s_d       <= 1'b1;
            r_p         <= 1'b0;
            r_err_short <= 1'b0;
            r_err_long  <= 1'b0;
            r_err_gap   <= 1'b0;
            r_width     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_s_d       <= w_s;
            r_p         <= w_p_next;
            r_err_short <= w_err_short_next;
            r_err_long  <= w_err_long_next;
            r_err_gap   <= w_err_gap_next;
            r_width     <= w_width_next;
        end
    end

    assign oP         = r_p;
    assign oWIDTH     = r_width;
    assign oERR_SHORT = r_err_short;
    assign oERR_LONG  = r_err_long;
    assign oERR_GAP   = r_err_gap;

endmodule

// File: doc/pulse_width_decode.md
Name: pulse_width_decode

Overview:
- Receive-side counterpart of the pulse stretcher in the common user library.
- Recovers single-cycle trigger events from stretched level pulses, for example trigger pulses crossing from the camera/sensor timing domain into processing logic.
- Measures the high width of each input pulse and validates it against a [MIN, MAX] window and a minimum low gap.
- Emits a one-cycle pulse, or an error flag, once per input pulse.

Parameters:
MIN_WIDTH, 4, minimum accepted high width in clock cycles (>=1)
MAX_WIDTH, 16, maximum accepted high width in clock cycles (>=MIN_WIDTH)
GAP_MIN, 2, minimum number of low samples required before an accepted rise (>=1)

Ports:
CLK  input  1  system clock; all logic on posedge
RST_N  input  1  asynchronous active-low reset
iS  input  1  stretched pulse input (level)
oP  output  1  one-cycle pulse: valid pulse decoded
oWIDTH  output  $clog2(MAX_WIDTH+1)  width of last valid pulse
oERR_SHORT  output  1  one-cycle flag: pulse narrower than MIN_WIDTH
oERR_LONG  output  1  one-cycle flag: pulse exceeded MAX_WIDTH
oERR_GAP  output  1  one-cycle flag: rise arrived before GAP_MIN low samples elapsed

Behaviour:
- Interface: one clock domain. Reset is asynchronous and active-low. Clock port is CLK, reset port is RST_N.
- Reset values:
  - all outputs 0; state IDLE; width and gap counters 0.
  - Previous-sample register s_d resets to 1, so a level already high at reset release is NOT a rise. It is ignored until s falls.
- Signal s is iS, or its synchronized copy (see Optional Feature). Rise = s & ~s_d.
- Width N = number of consecutive posedges at which s is sampled high.
- States and transitions:
  - IDLE: rise -> MEASURE with cnt=1.
  - MEASURE, s high: cnt++. If cnt==MAX_WIDTH and s still high -> assert oERR_LONG for one cycle, go to DISCARD.
  - MEASURE, s low:
    - cnt>=MIN_WIDTH -> oP=1 and oWIDTH<=cnt.
    - otherwise -> oERR_SHORT=1; oWIDTH unchanged.
    - In both cases go to GUARD, gap=1.
  - GUARD, s low: gap++ (saturates at GAP_MIN); gap==GAP_MIN -> IDLE.
  - GUARD, rise with gap<GAP_MIN: oERR_GAP=1, go to DISCARD.
  - DISCARD: no outputs; s low -> GUARD with gap=1.
- Latency: oP/oERR_SHORT are registered and high for exactly the cycle following the posedge at which s is first sampled low. oERR_LONG is high for the cycle following the (MAX_WIDTH+1)th high sample.
- Flags: at most one of oP/oERR_* is high in any cycle. Each is high for exactly one cycle per event.
- oWIDTH holds the last valid width until the next valid pulse.
- Counters: cnt width $clog2(MAX_WIDTH+1); cnt never exceeds MAX_WIDTH.
- Boundaries:
  - N==MIN_WIDTH and N==MAX_WIDTH are both valid.
  - Single-cycle high with MIN_WIDTH=1 is valid.
  - A rise while in IDLE after reset release requires no gap check.
- Reset mid-operation: immediate return to IDLE; any partial measurement is discarded.

Optional Feature:
- Macro: PULSE_WIDTH_DECODE_SYNC_EN.
- Defined: iS passes through a 2-FF synchronizer (reset value 1) before s. All output latencies grow by 2 cycles; widths are unchanged.
- Undefined: s=iS directly, and iS must already be synchronous to CLK.

Decomposition:
- Shared package:
  - state encoding constants (IDLE, MEASURE, GUARD, DISCARD; 2 bits);
  - width function WIDTH_W = $clog2(MAX_WIDTH+1).
- One natural sub-module, pulse_width_ctr: saturating up-counter with load-to-1, increment, and ==limit compare. Instantiate it twice, once for width and once for gap.

Test Plan:
- After reset with iS low for 4 cycles, drive a width-8 high pulse -> oP high 1 cycle after first low sample; oWIDTH=8; no error flags.
- Width 3 -> oERR_SHORT one cycle; no oP; oWIDTH keeps the prior value 8.
- Widths 4 and 16, separated by 4 low cycles -> two oP, oWIDTH=4 then 16.
- Width 20 -> oERR_LONG one cycle after the 17th high sample; no oP or oERR_SHORT at the fall.
- Pulse of 6, then 1 low cycle, then a pulse of 6 -> first gives oP (width 6); second gives oERR_GAP at its rise and no oP. Repeat with 2 low cycles -> both accepted.
- Assert RST_N low during high sample 5 of a pulse and release with iS still high -> no outputs until iS falls. Then a width-6 pulse -> oP, oWIDTH=6.
- With PULSE_WIDTH_DECODE_SYNC_EN defined, rerun the first scenario -> identical oWIDTH; oP 2 cycles later.
